// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 by default) gated by a synchronized PLL lock.
// All outputs are registered and reflect the h/v position they are launched with.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int LOCK_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LCW     = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t         state;
    logic           sync1, lk_s;
    logic [LCW-1:0] lock_cnt;
    logic [9:0]     h_cnt, v_cnt;
    logic [9:0]     h_nxt, v_nxt;
    logic [9:0]     dh, dv;
    logic           go_run, dec_de;

    always_comb begin
        h_nxt = (h_cnt == H_LAST) ? 10'd0 : h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST)
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end

    // Position the registered outputs will describe next cycle; entering RUN starts at (0,0).
    always_comb begin
        go_run = 1'b0;
        dh     = '0;
        dv     = '0;
        case (state)
            WAIT_LOCK: go_run = lk_s && (lock_cnt == LOCK_LAST);
            RUN: begin
                go_run = lk_s;
                dh     = h_nxt;
                dv     = v_nxt;
            end
            default: go_run = 1'b0;
        endcase
        dec_de = (dh < H_ACT) && (dv < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            lk_s        <= 1'b0;
            state       <= WAIT_LOCK;
            lock_cnt    <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk_s  <= sync1;
            if (go_run) begin
                state       <= RUN;
                lock_cnt    <= '0;
                h_cnt       <= dh;
                v_cnt       <= dv;
                hsync       <= (dh >= HS_BEG && dh <= HS_END) ? HS_ACT : ~HS_ACT;
                vsync       <= (dv >= VS_BEG && dv <= VS_END) ? VS_ACT : ~VS_ACT;
                de          <= dec_de;
                x           <= dec_de ? dh : 10'd0;
                y           <= dec_de ? dv : 10'd0;
                line_start  <= (dh == 10'd0);
                frame_start <= (dh == 10'd0) && (dv == 10'd0);
                running     <= 1'b1;
            end else begin
                // Lock lost (or not yet qualified): drop the raster immediately, no wrap effects.
                state       <= WAIT_LOCK;
                lock_cnt    <= (state == WAIT_LOCK && lk_s) ? lock_cnt + LCW'(1) : '0;
                h_cnt       <= '0;
                v_cnt       <= '0;
                hsync       <= ~HS_ACT;
                vsync       <= ~VS_ACT;
                de          <= 1'b0;
                x           <= '0;
                y           <= '0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
                running     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for lock and line timing, plus a
// shrunken, active-high-sync instance sharing the same inputs for whole-frame and mid-frame events.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;

    logic       b_hs, b_vs, b_de, b_ls, b_fs, b_run;
    logic [9:0] b_x, b_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_run;
    logic [9:0] s_x, s_y;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_b (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs), .running(b_run)
    );

    // Small raster: H_TOTAL = 32, V_TOTAL = 19, frame = 608 clocks; syncs active-high.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1), .VS_POL(1), .LOCK_WAIT(16)
    ) dut_s (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs), .running(s_run)
    );

    typedef struct {
        int         k;
        logic       de;
        logic       hs;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns the index n of the sample (taken just before rising edge n, edge 0 being the
    // first edge after this call) at which the default instance first reports running.
    task automatic count_to_run(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!b_run && n < 100);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_b_run"}, int'(b_run), 0);
        check({tag, "_b_de"},  int'(b_de), 0);
        check({tag, "_b_hs"},  int'(b_hs), 1);
        check({tag, "_b_vs"},  int'(b_vs), 1);
        check({tag, "_b_xy"},  int'(b_x) + int'(b_y), 0);
        check({tag, "_b_pulses"}, int'(b_ls) + int'(b_fs), 0);
        check({tag, "_s_run"}, int'(s_run), 0);
        check({tag, "_s_hs"},  int'(s_hs), 0);
        check({tag, "_s_vs"},  int'(s_vs), 0);
        check({tag, "_s_de"},  int'(s_de), 0);
    endtask

    task automatic check_start(input string tag);
        check({tag, "_b_fs"}, int'(b_fs), 1);
        check({tag, "_b_ls"}, int'(b_ls), 1);
        check({tag, "_b_de"}, int'(b_de), 1);
        check({tag, "_b_xy"}, int'(b_x) + int'(b_y), 0);
        check({tag, "_s_run"}, int'(s_run), 1);
        check({tag, "_s_fs"}, int'(s_fs), 1);
    endtask

    initial begin
        int n, k, cnt_de, cnt_hs, cnt_ls, cnt_fs, cnt_vs, vs_first, hs_first, xmax, ymax;
        logic seen_run;

        tbl[0]  = '{0,    1'b1, 1'b1, 10'd0,   10'd0, 1'b1, 1'b1};
        tbl[1]  = '{1,    1'b1, 1'b1, 10'd1,   10'd0, 1'b0, 1'b0};
        tbl[2]  = '{639,  1'b1, 1'b1, 10'd639, 10'd0, 1'b0, 1'b0};
        tbl[3]  = '{640,  1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0};
        tbl[4]  = '{655,  1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0};
        tbl[5]  = '{656,  1'b0, 1'b0, 10'd0,   10'd0, 1'b0, 1'b0};
        tbl[6]  = '{751,  1'b0, 1'b0, 10'd0,   10'd0, 1'b0, 1'b0};
        tbl[7]  = '{752,  1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0};
        tbl[8]  = '{799,  1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0};
        tbl[9]  = '{800,  1'b1, 1'b1, 10'd0,   10'd1, 1'b1, 1'b0};
        tbl[10] = '{801,  1'b1, 1'b1, 10'd1,   10'd1, 1'b0, 1'b0};
        tbl[11] = '{1599, 1'b0, 1'b1, 10'd0,   10'd0, 1'b0, 1'b0};

        // Reset and lock qualification.
        repeat (4) step();
        check_idle("reset");
        rst = 1'b0;
        pll_locked = 1'b1;
        count_to_run(n);
        check("lock_cycle", n, 18);
        check_start("first_run");

        // Line timing on the default raster; sample k = clocks since running rose.
        k = 0;
        for (int i = 0; i < 12; i++) begin
            while (k < tbl[i].k) begin
                step();
                k++;
            end
            check($sformatf("vec%0d_de", i), int'(b_de), int'(tbl[i].de));
            check($sformatf("vec%0d_hs", i), int'(b_hs), int'(tbl[i].hs));
            check($sformatf("vec%0d_x", i),  int'(b_x),  int'(tbl[i].x));
            check($sformatf("vec%0d_y", i),  int'(b_y),  int'(tbl[i].y));
            check($sformatf("vec%0d_ls", i), int'(b_ls), int'(tbl[i].ls));
            check($sformatf("vec%0d_fs", i), int'(b_fs), int'(tbl[i].fs));
            check($sformatf("vec%0d_vs", i), int'(b_vs), 1);
            check($sformatf("vec%0d_run", i), int'(b_run), 1);
        end

        // Third line (v=2) counted whole.
        step();
        cnt_de = 0; cnt_hs = 0; cnt_ls = 0; hs_first = -1; xmax = 0;
        for (int h = 0; h < 800; h++) begin
            if (b_de) cnt_de++;
            if (b_de && int'(b_x) > xmax) xmax = int'(b_x);
            if (!b_hs) begin
                cnt_hs++;
                if (hs_first < 0) hs_first = h;
            end
            if (b_ls) cnt_ls++;
            step();
        end
        check("line_de_count", cnt_de, 640);
        check("line_hs_count", cnt_hs, 96);
        check("line_hs_first", hs_first, 656);
        check("line_ls_count", cnt_ls, 1);
        check("line_x_max", xmax, 639);
        check("line_next_ls", int'(b_ls), 1);
        check("line_next_y", int'(b_y), 3);

        // Whole frame on the small raster.
        n = 0;
        while (!s_fs && n < 700) begin
            step();
            n++;
        end
        check("frame_sync_timeout", int'(n < 700), 1);
        cnt_de = 0; cnt_vs = 0; cnt_ls = 0; cnt_fs = 0; vs_first = -1; xmax = 0; ymax = 0;
        for (int f = 0; f < 608; f++) begin
            if (s_de) begin
                cnt_de++;
                if (int'(s_x) > xmax) xmax = int'(s_x);
                if (int'(s_y) > ymax) ymax = int'(s_y);
            end
            if (s_vs) begin
                cnt_vs++;
                if (vs_first < 0) vs_first = f;
            end
            if (s_ls) cnt_ls++;
            if (s_fs) cnt_fs++;
            step();
        end
        check("frame_de_count", cnt_de, 192);
        check("frame_vs_count", cnt_vs, 64);
        check("frame_vs_first", vs_first, 448);
        check("frame_ls_count", cnt_ls, 19);
        check("frame_fs_count", cnt_fs, 1);
        check("frame_x_max", xmax, 15);
        check("frame_y_max", ymax, 11);
        check("frame_period", int'(s_fs), 1);

        // Lock loss at v=5, h=10 of the small raster.
        repeat (170) step();
        check("loss_pre_x", int'(s_x), 10);
        check("loss_pre_y", int'(s_y), 5);
        pll_locked = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (s_run && n < 10);
        check("loss_latency", n, 3);
        check_idle("loss");
        check("loss_s_xy", int'(s_x) + int'(s_y), 0);
        pll_locked = 1'b1;
        count_to_run(n);
        check("relock_cycle", n, 18);
        check_start("relock");
        check("relock_s_xy", int'(s_x) + int'(s_y), 0);

        // Reset at v=3 of the small raster, then restart.
        repeat (101) step();
        check("rstmid_pre_y", int'(s_y), 3);
        rst = 1'b1;
        step();
        check_idle("rstmid");
        repeat (3) step();
        rst = 1'b0;
        count_to_run(n);
        check("rstmid_cycle", n, 18);
        check_start("rstmid_run");

        // Glitchy lock: high 10 cycles, low 1, then high.
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        pll_locked = 1'b1;
        seen_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (b_run || s_run) seen_run = 1'b1;
        end
        pll_locked = 1'b0;
        step();
        if (b_run || s_run) seen_run = 1'b1;
        pll_locked = 1'b1;
        check("glitch_no_early_run", int'(seen_run), 0);
        count_to_run(n);
        check("glitch_cycle", n, 18);
        check_start("glitch_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
